// File: rtl/rx_pix_pack.sv
// Receive-side RGB444 pixel packer: rebuilds frame geometry from the CC1200 sample stream and emits AXI4-Stream video.
// One cycle from an accepted sample to tvalid; a full FIFO drops samples and flags Overflow while geometry keeps advancing.

module pix_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  // Caller guarantees push only when !full || pop, and pop only when !empty.
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module rx_pix_pack #(
  parameter int LINE_PIX    = 640,
  parameter int FRAME_LINES = 480,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        RxValid,
  input  logic [11:0] RxData,
  input  logic        FrameSync,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tlast,
  output logic        m_axis_video_tuser,
  output logic        Overflow,
  output logic        ShortFrame,
  output logic [15:0] FrameCnt
);
  localparam int CW = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
  localparam int RW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_PIX - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt, cur_col;
  logic [RW-1:0] row, row_nxt, cur_row;
  logic          sof_arm, sof_nxt, cur_sof;
  logic          accept, eol, last_pix, frame_done;
  logic          push, pop, full, empty, drop;
  logic [13:0]   head;

  // A sync in the same cycle as a sample is applied first, so the sample lands at (0,0) with sof.
  always_comb begin
    cur_col    = FrameSync ? '0 : col;
    cur_row    = FrameSync ? '0 : row;
    cur_sof    = FrameSync | sof_arm;
    accept     = RxValid && (state == RUN || FrameSync);
    eol        = (cur_col == COL_LAST);
    last_pix   = eol && (cur_row == ROW_LAST);
    state_nxt  = state;
    col_nxt    = cur_col;
    row_nxt    = cur_row;
    sof_nxt    = cur_sof;
    frame_done = 1'b0;
    if (FrameSync) state_nxt = RUN;
    if (accept) begin
      sof_nxt = 1'b0;
      if (eol) begin
        col_nxt = '0;
        row_nxt = last_pix ? '0 : cur_row + RW'(1);
      end else begin
        col_nxt = cur_col + CW'(1);
      end
      if (last_pix) begin
        state_nxt  = IDLE;
        frame_done = 1'b1;
      end
    end
  end

  assign pop  = !empty && m_axis_video_tready;
  assign push = accept && (!full || pop);
  assign drop = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      sof_arm    <= 1'b0;
      Overflow   <= 1'b0;
      ShortFrame <= 1'b0;
      FrameCnt   <= '0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      row      <= row_nxt;
      sof_arm  <= sof_nxt;
      if (drop) Overflow <= 1'b1;
      if (FrameSync && state == RUN) ShortFrame <= 1'b1;
      if (frame_done) FrameCnt <= FrameCnt + 16'd1;
    end
  end

  pix_fifo #(.W(14), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   ({cur_sof, eol, RxData}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Payload is masked while empty so stale RAM never reaches the port.
  assign m_axis_video_tvalid = !empty;
  assign m_axis_video_tlast  = !empty && head[12];
  assign m_axis_video_tuser  = !empty && head[13];
  assign m_axis_video_tdata  = empty ? 24'd0 :
    {head[11:8], head[11:8], head[7:4], head[7:4], head[3:0], head[3:0]};
endmodule

// File: tb/tb_rx_pix_pack.sv
// Directed bench for rx_pix_pack with a 4x3 frame and a 4-entry FIFO.
module tb_rx_pix_pack;
  logic        clk = 1'b0;
  logic        rstn;
  logic        RxValid;
  logic [11:0] RxData;
  logic        FrameSync;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;
  logic        Overflow;
  logic        ShortFrame;
  logic [15:0] FrameCnt;

  int errors = 0;
  int checks = 0;
  logic [25:0] beats [$];

  rx_pix_pack #(.LINE_PIX(4), .FRAME_LINES(3), .FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .RxValid             (RxValid),
    .RxData              (RxData),
    .FrameSync           (FrameSync),
    .m_axis_video_tdata  (tdata),
    .m_axis_video_tvalid (tvalid),
    .m_axis_video_tready (tready),
    .m_axis_video_tlast  (tlast),
    .m_axis_video_tuser  (tuser),
    .Overflow            (Overflow),
    .ShortFrame          (ShortFrame),
    .FrameCnt            (FrameCnt)
  );

  always #5 clk = ~clk;

  // Beats are captured mid-cycle, ahead of the edge that pops them.
  always @(negedge clk) begin
    if (rstn && tvalid && tready) beats.push_back({tuser, tlast, tdata});
  end

  function automatic logic [23:0] expand(input logic [11:0] s);
    return {s[11:8], s[11:8], s[7:4], s[7:4], s[3:0], s[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [23:0] d,
                          input logic l, input logic u);
    if (idx >= beats.size()) begin
      checks++;
      errors++;
      $error("FAIL %s: beat %0d missing, observed %0d beats", tag, idx, beats.size());
    end else begin
      chk({tag, ".tdata"}, 32'(beats[idx][23:0]), 32'(d));
      chk({tag, ".tlast"}, 32'(beats[idx][24]), 32'(l));
      chk({tag, ".tuser"}, 32'(beats[idx][25]), 32'(u));
    end
  endtask

  initial begin
    rstn = 1'b0; RxValid = 1'b0; RxData = '0; FrameSync = 1'b0; tready = 1'b0;
    step(); step();
    chk("rst.tvalid", 32'(tvalid), 0);
    chk("rst.tlast", 32'(tlast), 0);
    chk("rst.tuser", 32'(tuser), 0);
    chk("rst.tdata", 32'(tdata), 0);
    chk("rst.overflow", 32'(Overflow), 0);
    chk("rst.shortframe", 32'(ShortFrame), 0);
    chk("rst.framecnt", 32'(FrameCnt), 0);
    rstn = 1'b1;

    // Samples with no preceding sync are discarded.
    tready = 1'b1;
    RxValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      RxData = 12'(i);
      step();
    end
    RxValid = 1'b0;
    step(); step();
    chk("idle.beats", 32'(beats.size()), 0);
    chk("idle.tvalid", 32'(tvalid), 0);
    chk("idle.framecnt", 32'(FrameCnt), 0);

    // Nominal 4x3 frame.
    beats.delete();
    FrameSync = 1'b1; step(); FrameSync = 1'b0;
    RxValid = 1'b1; RxData = 12'h000; step();
    chk("lat.tvalid", 32'(tvalid), 1);
    chk("lat.tuser", 32'(tuser), 1);
    chk("lat.tdata", 32'(tdata), 0);
    for (int i = 1; i < 12; i++) begin
      RxData = 12'(i);
      step();
    end
    RxValid = 1'b0;
    chk("nom.framecnt", 32'(FrameCnt), 1);
    repeat (4) step();
    chk("nom.beats", 32'(beats.size()), 12);
    for (int i = 0; i < 12; i++)
      chk_beat($sformatf("nom.b%0d", i), i, expand(12'(i)), (i % 4) == 3, i == 0);
    chk("nom.b5_const", 32'(beats[5][23:0]), 32'h000055);
    // Back in IDLE: further samples must not come out.
    RxValid = 1'b1; RxData = 12'h0FF; step(); step(); RxValid = 1'b0;
    repeat (3) step();
    chk("nom.idle_after", 32'(beats.size()), 12);

    // Colour expansion, sync and sample in the same cycle.
    beats.delete();
    FrameSync = 1'b1; RxValid = 1'b1; RxData = 12'hA5C; step();
    FrameSync = 1'b0; RxData = 12'h000;
    repeat (11) step();
    RxValid = 1'b0;
    repeat (4) step();
    chk_beat("col.b0", 0, 24'hAA55CC, 1'b0, 1'b1);
    chk("col.beats", 32'(beats.size()), 12);
    chk("col.framecnt", 32'(FrameCnt), 2);
    chk("col.shortframe", 32'(ShortFrame), 0);

    // Back-pressure into a 4-entry FIFO.
    beats.delete();
    tready = 1'b0;
    FrameSync = 1'b1; step(); FrameSync = 1'b0;
    RxValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      RxData = 12'(i + 1);
      step();
    end
    chk("bp.overflow_pre", 32'(Overflow), 0);
    RxData = 12'd5; step();
    chk("bp.overflow_set", 32'(Overflow), 1);
    RxData = 12'd6; step();
    RxValid = 1'b0;
    chk("bp.hold_tvalid", 32'(tvalid), 1);
    chk("bp.hold_tdata", 32'(tdata), 32'(expand(12'd1)));
    tready = 1'b1;
    repeat (6) step();
    chk("bp.beats", 32'(beats.size()), 4);
    for (int i = 0; i < 4; i++)
      chk_beat($sformatf("bp.b%0d", i), i, expand(12'(i + 1)), i == 3, i == 0);
    // Dropped pixels took row1 col0/col1, so the next two land on col2/col3.
    RxValid = 1'b1;
    RxData = 12'd7; step();
    RxData = 12'd8; step();
    RxValid = 1'b0;
    repeat (3) step();
    chk_beat("bp.b4", 4, expand(12'd7), 1'b0, 1'b0);
    chk_beat("bp.b5", 5, expand(12'd8), 1'b1, 1'b0);
    RxValid = 1'b1;
    for (int i = 9; i < 13; i++) begin
      RxData = 12'(i);
      step();
    end
    RxValid = 1'b0;
    repeat (3) step();
    chk("bp.beats_all", 32'(beats.size()), 10);
    chk_beat("bp.b9", 9, expand(12'd12), 1'b1, 1'b0);
    chk("bp.framecnt", 32'(FrameCnt), 3);

    // Short frame: resync after 5 samples, coinciding with a sample.
    beats.delete();
    FrameSync = 1'b1; step(); FrameSync = 1'b0;
    RxValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      RxData = 12'h020 + 12'(i);
      step();
    end
    tready = 1'b0;
    RxData = 12'h023; step();
    RxData = 12'h024; step();
    chk("sf.shortframe_pre", 32'(ShortFrame), 0);
    FrameSync = 1'b1; RxData = 12'h3F0; step();
    FrameSync = 1'b0; RxValid = 1'b0;
    chk("sf.shortframe_set", 32'(ShortFrame), 1);
    chk("sf.head", 32'(tdata), 32'(expand(12'h022)));
    tready = 1'b1;
    repeat (6) step();
    chk("sf.beats", 32'(beats.size()), 6);
    for (int i = 0; i < 5; i++)
      chk_beat($sformatf("sf.b%0d", i), i, expand(12'h020 + 12'(i)), i == 3, i == 0);
    chk_beat("sf.b5", 5, 24'h33FF00, 1'b0, 1'b1);
    chk("sf.framecnt", 32'(FrameCnt), 3);

    // Reset mid-frame with two pixels queued.
    tready = 1'b0;
    RxValid = 1'b1;
    RxData = 12'h111; step();
    RxData = 12'h222; step();
    RxValid = 1'b0;
    chk("mr.tvalid_pre", 32'(tvalid), 1);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("mr.tvalid", 32'(tvalid), 0);
    chk("mr.tlast", 32'(tlast), 0);
    chk("mr.tuser", 32'(tuser), 0);
    chk("mr.tdata", 32'(tdata), 0);
    chk("mr.overflow", 32'(Overflow), 0);
    chk("mr.shortframe", 32'(ShortFrame), 0);
    chk("mr.framecnt", 32'(FrameCnt), 0);
    beats.delete();
    tready = 1'b1;
    FrameSync = 1'b1; step(); FrameSync = 1'b0;
    RxValid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      RxData = 12'h400 + 12'(i);
      step();
    end
    RxValid = 1'b0;
    repeat (4) step();
    chk("mr.beats", 32'(beats.size()), 12);
    chk_beat("mr.b0", 0, 24'h440000, 1'b0, 1'b1);
    chk_beat("mr.b11", 11, expand(12'h40B), 1'b1, 1'b0);
    chk("mr.framecnt_after", 32'(FrameCnt), 1);
    chk("mr.shortframe_after", 32'(ShortFrame), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
